// File: rtl/mem_rr_arbiter.sv
// Two-port round-robin arbiter sharing one memory bus between the vector core (port 0) and a loader/DMA (port 1).
// Latency: grant, downstream request and response steering are combinational (zero added cycles).
// Backpressure: grants stop while MAX_OUTST transactions are in flight; requesters hold req/payload until gnt.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   p_req_i/p_gnt_o         per-port request and one-hot grant
//   p_addr_i/p_we_i/p_be_i/p_wdata_i   per-port request payload
//   p_rvalid_o/p_err_o      per-port response, steered by the in-order ID FIFO
//   p_rdata_o               read data, broadcast to both ports
//   mem_*_o / mem_*_i       downstream bus (no grant; in-order responses, latency >= 1)
//   outst_o                 in-flight transaction count
//   spurious_o              sticky: a response arrived with nothing in flight
module mem_rr_arbiter #(
  parameter int MAX_OUTST = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  p_req_i,
  output logic [1:0]                  p_gnt_o,
  input  logic [1:0][31:0]            p_addr_i,
  input  logic [1:0]                  p_we_i,
  input  logic [1:0][3:0]             p_be_i,
  input  logic [1:0][31:0]            p_wdata_i,
  output logic [1:0]                  p_rvalid_o,
  output logic [1:0]                  p_err_o,
  output logic [31:0]                 p_rdata_o,
  output logic                        mem_req_o,
  output logic [31:0]                 mem_addr_o,
  output logic                        mem_we_o,
  output logic [3:0]                  mem_be_o,
  output logic [31:0]                 mem_wdata_o,
  input  logic                        mem_rvalid_i,
  input  logic                        mem_err_i,
  input  logic [31:0]                 mem_rdata_i,
  output logic [$clog2(MAX_OUTST):0]  outst_o,
  output logic                        spurious_o
);

  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

  logic                 prio;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [MAX_OUTST-1:0] id_fifo;   // one bit per entry: issuing port index
  logic                 spurious;

  logic       can_issue;
  logic [1:0] gnt;
  logic       gnt_idx;
  logic       push;
  logic       pop;
  logic       head;

  always_comb begin
    // Full is judged on the registered count only: a pop this cycle does not
    // free a slot until the next cycle.
    can_issue = (count < MAX_CNT);
    gnt       = 2'b00;
    gnt_idx   = 1'b0;
    if (!rst_i && can_issue) begin
      unique case (p_req_i)
        2'b01:   begin gnt = 2'b01; gnt_idx = 1'b0; end
        2'b10:   begin gnt = 2'b10; gnt_idx = 1'b1; end
        2'b11:   begin gnt_idx = prio; gnt = prio ? 2'b10 : 2'b01; end
        default: begin gnt = 2'b00; gnt_idx = 1'b0; end
      endcase
    end
    push = |gnt;
  end

  assign p_gnt_o     = gnt;
  // With no grant gnt_idx is 0, so the idle bus shows port 0's payload.
  assign mem_req_o   = push;
  assign mem_addr_o  = p_addr_i[gnt_idx];
  assign mem_we_o    = p_we_i[gnt_idx];
  assign mem_be_o    = p_be_i[gnt_idx];
  assign mem_wdata_o = p_wdata_i[gnt_idx];

  assign head = id_fifo[rd_ptr];
  assign pop  = !rst_i && mem_rvalid_i && (count != '0);

  always_comb begin
    p_rvalid_o = 2'b00;
    p_err_o    = 2'b00;
    if (pop) begin
      p_rvalid_o[head] = 1'b1;
      p_err_o[head]    = mem_err_i;
    end
  end

  assign p_rdata_o  = mem_rdata_i;
  assign outst_o    = count;
  assign spurious_o = spurious;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      id_fifo  <= '0;
      spurious <= 1'b0;
    end else begin
      if (push) begin
        id_fifo[wr_ptr] <= gnt_idx;
        wr_ptr          <= wr_ptr + 1'b1;   // power-of-two depth: natural wrap
        prio            <= ~gnt_idx;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (mem_rvalid_i && (count == '0)) begin
        spurious <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
module tb_mem_rr_arbiter;
  localparam int MAX = 4;
  localparam int CW  = $clog2(MAX) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       p_req;
  logic [1:0]       p_gnt;
  logic [1:0][31:0] p_addr;
  logic [1:0]       p_we;
  logic [1:0][3:0]  p_be;
  logic [1:0][31:0] p_wdata;
  logic [1:0]       p_rvalid;
  logic [1:0]       p_err;
  logic [31:0]      p_rdata;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;
  logic             mem_rvalid;
  logic             mem_err;
  logic [31:0]      mem_rdata;
  logic [CW-1:0]    outst;
  logic             spurious;

  mem_rr_arbiter #(.MAX_OUTST(MAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .p_req_i(p_req), .p_gnt_o(p_gnt), .p_addr_i(p_addr), .p_we_i(p_we),
    .p_be_i(p_be), .p_wdata_i(p_wdata), .p_rvalid_o(p_rvalid), .p_err_o(p_err),
    .p_rdata_o(p_rdata), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_err_i(mem_err), .mem_rdata_i(mem_rdata),
    .outst_o(outst), .spurious_o(spurious)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of issuing port numbers, a preferred port and a sticky flag.
  int  q[$];
  int  m_prio = 0;
  bit  m_spur = 0;
  bit  auto_resp = 0;
  logic last_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : model
    logic [1:0] eg;
    logic [1:0] erv;
    logic [1:0] eer;
    int idx;
    if (rst) begin
      q.delete();
      m_prio = 0;
      m_spur = 0;
    end
    eg = 2'b00;
    if (!rst && q.size() < MAX) begin
      if (p_req == 2'b11) eg = (m_prio == 1) ? 2'b10 : 2'b01;
      else                eg = p_req;
    end
    idx = eg[1] ? 1 : 0;
    erv = 2'b00;
    eer = 2'b00;
    if (!rst && mem_rvalid && q.size() > 0) begin
      erv[q[0]] = 1'b1;
      eer[q[0]] = mem_err;
    end
    chk("m_gnt",      {30'd0, p_gnt},    {30'd0, eg});
    chk("m_mem_req",  {31'd0, mem_req},  {31'd0, |eg});
    chk("m_addr",     mem_addr,          p_addr[idx]);
    chk("m_we",       {31'd0, mem_we},   {31'd0, p_we[idx]});
    chk("m_be",       {28'd0, mem_be},   {28'd0, p_be[idx]});
    chk("m_wdata",    mem_wdata,         p_wdata[idx]);
    chk("m_rvalid",   {30'd0, p_rvalid}, {30'd0, erv});
    chk("m_err",      {30'd0, p_err},    {30'd0, eer});
    chk("m_rdata",    p_rdata,           mem_rdata);
    chk("m_outst",    32'(outst),        32'(q.size()));
    chk("m_spurious", {31'd0, spurious}, {31'd0, m_spur});
    // Advance the model to the state after the coming rising edge.
    if (!rst) begin
      if (mem_rvalid) begin
        if (q.size() > 0) void'(q.pop_front());
        else              m_spur = 1;
      end
      if (eg != 2'b00) begin
        q.push_back(idx);
        m_prio = (idx == 0) ? 1 : 0;
      end
    end
    last_req = mem_req;
  end

  // Advance one cycle; inputs change just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    mem_rdata = $urandom;
    if (auto_resp) begin
      mem_rvalid = last_req;
      mem_err    = 1'b0;
    end
  endtask

  int g0, r0, r1;

  initial begin
    rst        = 1'b1;
    p_req      = 2'b11;
    p_addr[0]  = 32'h0000_1000;
    p_addr[1]  = 32'hFF00_2000;
    p_we       = 2'b10;
    p_be[0]    = 4'hF;
    p_be[1]    = 4'h3;
    p_wdata[0] = 32'hA5A5_0000;
    p_wdata[1] = 32'h5A5A_1111;
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    mem_rdata  = 32'h0;

    // Reset forces grants off even with both ports requesting.
    @(negedge clk);
    chk("rst_gnt",   {30'd0, p_gnt}, 32'h0);
    chk("rst_req",   {31'd0, mem_req}, 32'h0);
    chk("rst_outst", 32'(outst), 32'h0);
    cyc();
    rst   = 1'b0;
    p_req = 2'b00;
    cyc();

    // Port 0 alone, 8 back-to-back reads, memory latency 1.
    auto_resp = 1;
    g0 = 0; r0 = 0; r1 = 0;
    for (int i = 0; i < 10; i++) begin
      p_req     = (i < 8) ? 2'b01 : 2'b00;
      p_addr[0] = 32'h100 + 32'(i * 4);
      p_we[0]   = 1'b0;
      @(negedge clk);
      if (p_gnt == 2'b01)    g0++;
      if (p_rvalid == 2'b01) r0++;
      if (p_rvalid[1])       r1++;
      cyc();
    end
    chk("p0_grants",   32'(g0), 32'd8);
    chk("p0_rvalids",  32'(r0), 32'd8);
    chk("p0_no_port1", 32'(r1), 32'd0);

    // Both ports requesting after reset: strict alternation starting at port 0.
    rst = 1'b1;
    cyc();
    rst       = 1'b0;
    p_addr[0] = 32'h0000_1000;
    p_addr[1] = 32'h0000_2000;
    p_we      = 2'b01;
    for (int i = 0; i < 8; i++) begin
      p_req = 2'b11;
      @(negedge clk);
      chk("alt_gnt",  {30'd0, p_gnt}, (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("alt_addr", mem_addr, (i % 2 == 0) ? 32'h1000 : 32'h2000);
      cyc();
    end
    p_req = 2'b00;
    cyc();
    cyc();

    // Memory withholds responses: four grants, then the FIFO is full.
    auto_resp  = 0;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      p_req     = 2'b01;
      p_addr[0] = 32'h3000 + 32'(i * 4);
      @(negedge clk);
      chk("fill_gnt", {30'd0, p_gnt}, (i < 4) ? 32'h1 : 32'h0);
      cyc();
    end
    @(negedge clk);
    chk("full_outst", 32'(outst), 32'd4);
    cyc();
    mem_rvalid = 1'b1;
    @(negedge clk);
    chk("full_pop_gnt",    {30'd0, p_gnt}, 32'h0);
    chk("full_pop_rvalid", {30'd0, p_rvalid}, 32'h1);
    cyc();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("resume_outst", 32'(outst), 32'd3);
    chk("resume_gnt",   {30'd0, p_gnt}, 32'h1);
    cyc();

    // Drain to two, then push (port 1) and pop together.
    p_req      = 2'b00;
    mem_rvalid = 1'b1;
    cyc();
    cyc();
    p_req     = 2'b10;
    p_addr[1] = 32'h0000_4000;
    @(negedge clk);
    chk("pp_outst_before", 32'(outst), 32'd2);
    chk("pp_gnt",          {30'd0, p_gnt}, 32'h2);
    chk("pp_rvalid",       {30'd0, p_rvalid}, 32'h1);
    cyc();
    p_req = 2'b00;
    @(negedge clk);
    chk("pp_outst_after", 32'(outst), 32'd2);
    chk("pp_order0",      {30'd0, p_rvalid}, 32'h1);
    cyc();
    mem_err = 1'b1;
    @(negedge clk);
    chk("err_rvalid", {30'd0, p_rvalid}, 32'h2);
    chk("err_err",    {30'd0, p_err}, 32'h2);
    cyc();
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    @(negedge clk);
    chk("drain_outst",    32'(outst), 32'd0);
    chk("drain_spurious", {31'd0, spurious}, 32'h0);
    cyc();

    // Reset with three in flight; their late responses become spurious.
    for (int i = 0; i < 3; i++) begin
      p_req = 2'b01;
      cyc();
    end
    p_req = 2'b00;
    @(negedge clk);
    chk("pre_rst_outst", 32'(outst), 32'd3);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_clr_outst", 32'(outst), 32'd0);
    cyc();
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_rvalid", {30'd0, p_rvalid}, 32'h0);
      cyc();
    end
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("late_spurious", {31'd0, spurious}, 32'h1);
    chk("late_outst",    32'(outst), 32'd0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Two-port round-robin arbiter that shares the single SoC memory bus (SRAM plus the 0xFF00xxxx register window) between the vector core's data port (port 0) and a second requester such as a UART program loader or DMA engine (port 1). It grants at most one request per cycle and forwards it combinationally to the downstream bus. It also tracks outstanding transactions in an in-order ID FIFO, so each `rvalid`/`err` response is steered back to the port that issued the request.

## Interface

Parameters:
- `MAX_OUTST`, default 4: maximum in-flight downstream requests; ID FIFO depth; power of two, ≥2.

Ports (per-port signals are packed `[1:0]` arrays; index 0 = port 0):
- `clk_i` input 1: clock.
- `rst_i` input 1: asynchronous, active-high reset.
- `p_req_i` input 2: per-port request.
- `p_gnt_o` output 2: per-port grant; one-hot or zero.
- `p_addr_i` input 2x32: byte address.
- `p_we_i` input 2: write enable.
- `p_be_i` input 2x4: byte enables.
- `p_wdata_i` input 2x32: write data.
- `p_rvalid_o` output 2: response valid, routed to the issuing port.
- `p_err_o` output 2: bus error, routed with rvalid.
- `p_rdata_o` output 32: read data, broadcast to both ports.
- `mem_req_o` output 1: downstream request.
- `mem_addr_o` output 32: downstream address.
- `mem_we_o` output 1: downstream write enable.
- `mem_be_o` output 4: downstream byte enables.
- `mem_wdata_o` output 32: downstream write data.
- `mem_rvalid_i` input 1: downstream response, in order, latency ≥1 cycle.
- `mem_err_i` input 1: downstream error, valid with `mem_rvalid_i`.
- `mem_rdata_i` input 32: downstream read data.
- `outst_o` output log2(MAX_OUTST)+1: current in-flight count.
- `spurious_o` output 1: sticky flag, set by a response arriving with no transaction in flight.

## Operation

- Downstream has no grant; every `mem_req_o` cycle is one accepted transaction.
- Requesters hold `req` and all payload signals stable until `gnt` is high in the same cycle.
- Grant enable: `can_issue = (count < MAX_OUTST)`. When `can_issue` is low, `p_gnt_o = 0` and `mem_req_o = 0`.
- Arbitration state: `prio` is a 1-bit register naming the preferred port.
  - Only one port requesting: that port is granted.
  - Both ports requesting: port `prio` is granted.
  - After any grant, `prio` is set to the non-granted port index.
- Mux: `mem_*_o` carry the granted port's payload. When there is no grant, `mem_req_o = 0` and the payload is port 0's (don't-care).
- ID FIFO:
  - On a grant, push the granted index.
  - On `mem_rvalid_i` with `count > 0`, pop the head.
  - Push and pop in the same cycle leave the count unchanged; the write pointer and read pointer wrap modulo MAX_OUTST.
- Response routing: `p_rvalid_o[h] = mem_rvalid_i & (count>0)` and `p_err_o[h] = mem_err_i & mem_rvalid_i & (count>0)`, where `h` is the FIFO head. The other port's bits are 0. `p_rdata_o = mem_rdata_i` always.
- Spurious response: `mem_rvalid_i` with `count == 0` is dropped (no `p_rvalid_o`) and sets `spurious_o`. The flag clears only on reset.

## Timing

- Grant and downstream request are combinational from `p_req_i`, `count` and `prio`: zero added latency.
- Response routing is combinational from `mem_rvalid_i` and the FIFO head: zero added latency.
- `prio`, the FIFO pointers, `count` and `spurious_o` update on the rising edge of `clk_i`.
- Reset values: `prio = 0`, `count = 0`, pointers 0, `spurious_o = 0`.
  - Consequently, during reset `p_gnt_o` is driven by the request inputs only after reset deasserts. While `rst_i` is high, `p_gnt_o`, `mem_req_o`, `p_rvalid_o` and `p_err_o` are forced to 0.
- Reset mid-operation: in-flight entries are discarded. Responses arriving after reset from pre-reset requests are dropped and set `spurious_o`.
- Full FIFO: with `count == MAX_OUTST`, no grant is issued even if a response pops in the same cycle; issue resumes the following cycle.
- Back-to-back: with downstream latency 1 and MAX_OUTST ≥ 2, a single requester sustains one grant per cycle.

## Test plan

- Port 0 only, 8 back-to-back reads, mem latency 1 → 8 consecutive grants; `p_rvalid_o = 2'b01` on cycles 1..8; `p_rvalid_o[1]` never set.
- Both ports requesting continuously, reset `prio = 0` → grant sequence 0,1,0,1,…; each response routed to the matching port; `mem_addr_o` alternates between the two ports' addresses.
- MAX_OUTST = 4, memory withholds rvalid → 4 grants, then `p_gnt_o = 0` and `outst_o = 4`. A single rvalid pops the head, and a grant resumes the next cycle.
- Simultaneous push and pop at `count = 2` → `outst_o` stays 2; routing follows issue order.
- Downstream `err` with rvalid for a port-1 transaction → `p_err_o = 2'b10`, `p_rvalid_o = 2'b10`, port 0 unaffected.
- Assert `rst_i` with 3 in flight, then deliver 3 rvalids → all dropped, `spurious_o = 1`, `outst_o = 0`.
